// File: rtl/rom_arb_pkg.sv
// Shared types and default constants for the waveform-ROM share arbiter.
package rom_arb_pkg;

    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    localparam int N_REQ_DEF          = 4;
    localparam int ROM_ADDR_WIDTH_DEF = 12;
    localparam int ROM_WIDTH_DEF      = 18;
    localparam int MAX_LOCK_DEF       = 16;
    localparam int GRANT_CNT_W        = 16;

endpackage

// File: rtl/rr_pick.sv
// Combinational one-hot picker: rotating search from ptr_i, or from index 0 when fixed priority.
module rr_pick
    import rom_arb_pkg::*;
#(
    parameter int N  = N_REQ_DEF,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    input  logic          fixed_prio_i,
    output logic [N-1:0]  grant_o
);

    always_comb begin
        int   start;
        int   idx;
        logic found;
        grant_o = '0;
        found   = 1'b0;
        start   = fixed_prio_i ? 0 : int'(ptr_i);
        idx     = 0;
        for (int k = 0; k < N; k++) begin
            idx = (start + k) % N;
            if (!found && req_i[idx]) begin
                grant_o[idx] = 1'b1;
                found        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rom_share_arbiter.sv
// Shares one registered-output waveform ROM among N_REQ readers, with optional bounded grant locking.
//  state  | meaning
//  ARB    | free arbitration (round-robin from ptr, or fixed priority)
//  LOCKED | lock_owner keeps the ROM while valid, up to MAX_LOCK grants
module rom_share_arbiter
    import rom_arb_pkg::*;
#(
    parameter int N_REQ          = N_REQ_DEF,
    parameter int ROM_ADDR_WIDTH = ROM_ADDR_WIDTH_DEF,
    parameter int ROM_WIDTH      = ROM_WIDTH_DEF,
    parameter int MAX_LOCK       = MAX_LOCK_DEF
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [N_REQ-1:0]                  req_valid,
    input  logic [N_REQ*ROM_ADDR_WIDTH-1:0]   req_addr,
    input  logic [N_REQ-1:0]                  req_lock,
    output logic [N_REQ-1:0]                  req_ready,
    input  logic                              fixed_prio,
    output logic                              rom_ce,
    output logic [ROM_ADDR_WIDTH-1:0]         rom_addr,
    input  logic [ROM_WIDTH-1:0]              rom_data,
    output logic [N_REQ-1:0]                  rsp_valid,
    output logic [ROM_WIDTH-1:0]              rsp_data,
    output logic [GRANT_CNT_W-1:0]            grant_cnt
);

    localparam int PW  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int LCW = $clog2(MAX_LOCK + 1);

    arb_state_e             state_q, state_d;
    logic [PW-1:0]          ptr_q, ptr_d;
    logic [PW-1:0]          owner_q, owner_d;
    logic [LCW-1:0]         lock_cnt_q, lock_cnt_d;
    logic [N_REQ-1:0]       rsp_valid_q;
    logic [GRANT_CNT_W-1:0] grant_cnt_q;

    logic [N_REQ-1:0]       pick_grant;
    logic [PW-1:0]          pick_idx;
    logic [N_REQ-1:0]       grant;
    logic [PW-1:0]          gidx;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] i);
        return PW'((int'(i) + 1) % N_REQ);
    endfunction

    rr_pick #(
        .N  (N_REQ),
        .PW (PW)
    ) u_pick (
        .req_i        (req_valid),
        .ptr_i        (ptr_q),
        .fixed_prio_i (fixed_prio),
        .grant_o      (pick_grant)
    );

    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick_grant[i]) pick_idx = PW'(i);
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        owner_d    = owner_q;
        lock_cnt_d = lock_cnt_q;
        grant      = '0;
        gidx       = pick_idx;
        if (!rst) begin
            unique case (state_q)
                ARB: begin
                    grant = pick_grant;
                    if (|pick_grant) begin
                        if (!fixed_prio) ptr_d = next_ptr(pick_idx);
                        if (req_lock[pick_idx] && (MAX_LOCK > 1)) begin
                            state_d    = LOCKED;
                            owner_d    = pick_idx;
                            lock_cnt_d = LCW'(1);
                        end
                    end
                end
                LOCKED: begin
                    gidx = owner_q;
                    if (req_valid[owner_q]) begin
                        grant[owner_q] = 1'b1;
                        lock_cnt_d     = lock_cnt_q + LCW'(1);
                        if (!fixed_prio) ptr_d = next_ptr(owner_q);
                        if (!req_lock[owner_q]) begin
                            state_d    = ARB;
                            lock_cnt_d = '0;
                        end else if (int'(lock_cnt_q) + 1 >= MAX_LOCK) begin
                            // forced release: others must get a turn next cycle
                            state_d    = ARB;
                            lock_cnt_d = '0;
                            ptr_d      = next_ptr(owner_q);
                        end
                    end else begin
                        state_d    = ARB;
                        lock_cnt_d = '0;
                    end
                end
                default: state_d = ARB;
            endcase
        end
    end

    assign req_ready = grant;
    assign rom_ce    = |grant;
    assign rom_addr  = (|grant) ? req_addr[gidx*ROM_ADDR_WIDTH +: ROM_ADDR_WIDTH]
                                : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ARB;
            ptr_q       <= '0;
            owner_q     <= '0;
            lock_cnt_q  <= '0;
            rsp_valid_q <= '0;
            grant_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            lock_cnt_q  <= lock_cnt_d;
            rsp_valid_q <= grant;
            grant_cnt_q <= grant_cnt_q + GRANT_CNT_W'(rom_ce);
        end
    end

    // gating with rst guarantees a response in flight at reset never escapes
    assign rsp_valid = rsp_valid_q & {N_REQ{~rst}};
    assign rsp_data  = rom_data;
    assign grant_cnt = grant_cnt_q;

endmodule

// File: tb/tb_rom_share_arbiter.sv
// Self-checking bench for rom_share_arbiter: vector table, hand sequences, response scoreboard.
module tb_rom_share_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [47:0] req_addr;
    logic [3:0]  req_lock;
    logic [3:0]  req_ready;
    logic        fixed_prio;
    logic        rom_ce;
    logic [11:0] rom_addr;
    logic [17:0] rom_data;
    logic [3:0]  rsp_valid;
    logic [17:0] rsp_data;
    logic [15:0] grant_cnt;

    int errs   = 0;
    int checks = 0;
    int exp_cnt;

    typedef struct {
        logic [3:0]  v;
        logic [17:0] d;
    } rsp_t;
    rsp_t sb[$];

    typedef struct {
        logic [3:0]  v;
        logic [3:0]  lk;
        logic        fp;
        logic [47:0] addr;
        logic [3:0]  exp;
    } vec_t;
    vec_t vecs[9];

    localparam logic [47:0] ADDR  = {12'h7FF, 12'h400, 12'h123, 12'h0A5};
    localparam logic [47:0] ADDR2 = {12'h00C, 12'hABC, 12'hFFF, 12'h001};

    rom_share_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_addr   (req_addr),
        .req_lock   (req_lock),
        .req_ready  (req_ready),
        .fixed_prio (fixed_prio),
        .rom_ce     (rom_ce),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .grant_cnt  (grant_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [17:0] rom_f(input logic [11:0] a);
        return {a[5:0] ^ 6'h2A, a ^ 12'hC35};
    endfunction

    // External registered ROM
    always @(posedge clk) begin
        if (rom_ce) rom_data <= rom_f(rom_addr);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic reset_dut();
        rst        = 1'b1;
        req_valid  = 4'b1111;
        req_lock   = 4'b0000;
        fixed_prio = 1'b0;
        req_addr   = ADDR;
        #1;
        chk("rst_ready", 32'(req_ready), 0);
        chk("rst_rom_ce", 32'(rom_ce), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        @(posedge clk); #1;
        rst       = 1'b0;
        req_valid = 4'b0000;
        sb.delete();
        exp_cnt = 0;
        chk("rst_grant_cnt", 32'(grant_cnt), 0);
    endtask

    // One cycle: check the response due now, drive new request, check the grant.
    task automatic cyc(input logic [3:0] v, input logic [3:0] lk, input logic fp,
                       input logic [47:0] addr, input logic [3:0] exp, input string nm);
        rsp_t        e;
        logic [11:0] ea;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({nm, "_rsp_valid"}, 32'(rsp_valid), 32'(e.v));
            if (e.v != 0) chk({nm, "_rsp_data"}, 32'(rsp_data), 32'(e.d));
        end else begin
            chk({nm, "_rsp_idle"}, 32'(rsp_valid), 0);
        end
        req_valid  = v;
        req_lock   = lk;
        fixed_prio = fp;
        req_addr   = addr;
        #1;
        ea = 12'h000;
        for (int i = 0; i < 4; i++) begin
            if (exp[i]) ea = addr[i*12 +: 12];
        end
        chk({nm, "_ready"}, 32'(req_ready), 32'(exp));
        chk({nm, "_rom_ce"}, 32'(rom_ce), 32'(|exp));
        chk({nm, "_rom_addr"}, 32'(rom_addr), 32'(ea));
        e.v = exp;
        e.d = rom_f(ea);
        sb.push_back(e);
        if (|exp) exp_cnt++;
        @(posedge clk); #1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] rr_exp;
        rst = 1'b1; req_valid = '0; req_lock = '0; fixed_prio = 1'b0; req_addr = ADDR;
        @(posedge clk); #1;

        // Single-cycle vectors, each from a fresh reset (ptr=0, ARB)
        vecs[0] = '{4'b0000, 4'b0000, 1'b0, ADDR,  4'b0000};
        vecs[1] = '{4'b0001, 4'b0000, 1'b0, ADDR,  4'b0001};
        vecs[2] = '{4'b1000, 4'b0000, 1'b0, ADDR2, 4'b1000};
        vecs[3] = '{4'b0110, 4'b0000, 1'b0, ADDR2, 4'b0010};
        vecs[4] = '{4'b1111, 4'b0000, 1'b0, ADDR,  4'b0001};
        vecs[5] = '{4'b1010, 4'b0000, 1'b1, ADDR,  4'b0010};
        vecs[6] = '{4'b1100, 4'b0000, 1'b1, ADDR2, 4'b0100};
        vecs[7] = '{4'b1111, 4'b1111, 1'b0, ADDR2, 4'b0001};
        vecs[8] = '{4'b0100, 4'b0000, 1'b0, ADDR,  4'b0100}; // req 2 alone at 0x400
        for (int i = 0; i < 9; i++) begin
            reset_dut();
            cyc(vecs[i].v, vecs[i].lk, vecs[i].fp, vecs[i].addr, vecs[i].exp, $sformatf("vec%0d", i));
            cyc(4'b0000, 4'b0000, 1'b0, ADDR, 4'b0000, $sformatf("vec%0d_flush", i));
        end

        // Round-robin rotation with all requesters valid
        reset_dut();
        for (int i = 0; i < 8; i++) begin
            rr_exp = 4'b0001 << (i % 4);
            cyc(4'b1111, 4'b0000, 1'b0, ADDR, rr_exp, $sformatf("rr%0d", i));
        end
        cyc(4'b0000, 4'b0000, 1'b0, ADDR, 4'b0000, "rr_flush");
        chk("rr_grant_cnt", 32'(grant_cnt), 32'(exp_cnt));

        // Fixed priority: requester 3 starves
        reset_dut();
        for (int i = 0; i < 4; i++)
            cyc(4'b1010, 4'b0000, 1'b1, ADDR2, 4'b0010, $sformatf("fix%0d", i));
        cyc(4'b0000, 4'b0000, 1'b1, ADDR2, 4'b0000, "fix_flush");

        // Lock to requester 1: 16 grants then forced release to 2
        reset_dut();
        cyc(4'b0010, 4'b0010, 1'b0, ADDR, 4'b0010, "lock_first");
        for (int i = 0; i < 15; i++)
            cyc(4'b1111, 4'b0010, 1'b0, ADDR, 4'b0010, $sformatf("lock%0d", i));
        cyc(4'b1111, 4'b0010, 1'b0, ADDR, 4'b0100, "lock_release");
        chk("lock_grant_cnt17", 32'(grant_cnt), 17);
        cyc(4'b0000, 4'b0000, 1'b0, ADDR, 4'b0000, "lock_flush");
        chk("lock_grant_cnt", 32'(grant_cnt), 32'(exp_cnt));

        // Lock survives fixed_prio, then owner drops valid: no grant, back to RR at ptr=3
        reset_dut();
        cyc(4'b0100, 4'b0100, 1'b0, ADDR, 4'b0100, "lk2_take");
        cyc(4'b1111, 4'b0100, 1'b1, ADDR, 4'b0100, "lk2_fixed");
        cyc(4'b1011, 4'b0100, 1'b1, ADDR, 4'b0000, "lk2_drop");
        cyc(4'b1111, 4'b0000, 1'b0, ADDR, 4'b1000, "lk2_rr");
        cyc(4'b0000, 4'b0000, 1'b0, ADDR, 4'b0000, "lk2_flush");

        // Release on grant with lock deasserted
        reset_dut();
        cyc(4'b0010, 4'b0010, 1'b0, ADDR2, 4'b0010, "unlk_take");
        cyc(4'b1111, 4'b0000, 1'b0, ADDR2, 4'b0010, "unlk_last");
        cyc(4'b1111, 4'b0000, 1'b0, ADDR2, 4'b0100, "unlk_next");
        cyc(4'b0000, 4'b0000, 1'b0, ADDR2, 4'b0000, "unlk_flush");

        // Reset right after a grant drops the in-flight response and ptr
        reset_dut();
        cyc(4'b0001, 4'b0000, 1'b0, ADDR, 4'b0001, "mid_grant");
        reset_dut();
        cyc(4'b1111, 4'b0000, 1'b0, ADDR, 4'b0001, "mid_ptr0");
        cyc(4'b0000, 4'b0000, 1'b0, ADDR, 4'b0000, "mid_flush");

        // grant_cnt wrap
        reset_dut();
        req_valid = 4'b0001; req_lock = 4'b0000; fixed_prio = 1'b0; req_addr = ADDR;
        repeat (65535) @(posedge clk);
        #1;
        chk("wrap_ffff", 32'(grant_cnt), 32'h0000_FFFF);
        @(posedge clk); #1;
        chk("wrap_zero", 32'(grant_cnt), 0);
        req_valid = 4'b0000;

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/rom_share_arbiter.md
ROM_SHARE_ARBITER -- requirements
Module: rom_share_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters sharing one registered-output waveform ROM (range 2..8).
REQ-002 Parameter ROM_ADDR_WIDTH, default 12, ROM address width.
REQ-003 Parameter ROM_WIDTH, default 18, ROM data width.
REQ-004 Parameter MAX_LOCK, default 16, maximum consecutive grants to one locked requester.
REQ-005 clk  input  1  clock; all logic on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 req_valid  input  N_REQ  per-requester read request.
REQ-008 req_addr  input  N_REQ*ROM_ADDR_WIDTH  packed addresses; requester i at bits [i*ROM_ADDR_WIDTH +: ROM_ADDR_WIDTH].
REQ-009 req_lock  input  N_REQ  requester asks to keep the grant next cycle.
REQ-010 req_ready  output  N_REQ  one-hot grant; request i accepted when req_valid[i] & req_ready[i].
REQ-011 fixed_prio  input  1  1 = fixed priority (index 0 highest), 0 = round-robin.
REQ-012 rom_ce  output  1  ROM clock enable.
REQ-013 rom_addr  output  ROM_ADDR_WIDTH  ROM address.
REQ-014 rom_data  input  ROM_WIDTH  ROM registered output (1-cycle latency after rom_ce).
REQ-015 rsp_valid  output  N_REQ  one-hot response strobe.
REQ-016 rsp_data  output  ROM_WIDTH  response data, valid when any rsp_valid bit set.
REQ-017 grant_cnt  output  16  total accepted requests since reset.

Function
REQ-018 Grant, req_ready, rom_ce, rom_addr SHALL be combinational from req_valid, req_addr, req_lock, fixed_prio and state; at most one req_ready bit high; req_ready[i] only when req_valid[i].
REQ-019 rom_ce SHALL equal OR of granted valid; rom_addr SHALL equal winner's address, 0 when no grant.
REQ-020 Response latency SHALL be exactly 1 cycle: grant to requester i in cycle t -> rsp_valid[i]=1 in t+1, rsp_data=rom_data in t+1.
REQ-021 rsp_data SHALL be rom_data passed through unregistered; rsp_valid SHALL be registered.
REQ-022 Round-robin: search starts at pointer ptr; after a grant to i, ptr <= (i+1) mod N_REQ; ptr unchanged with no grant.
REQ-023 Fixed priority: lowest-index valid wins; ptr not updated.
REQ-024 FSM states ARB and LOCKED.
REQ-025 ARB -> LOCKED when granted requester has req_lock=1; lock_owner <= winner, lock_cnt <= 1.
REQ-026 In LOCKED, owner SHALL win if req_valid[owner]=1, regardless of others; lock_cnt increments per grant.
REQ-027 LOCKED -> ARB when req_valid[owner]=0, req_lock[owner]=0 on a grant, or lock_cnt reaches MAX_LOCK on a grant; that cycle's grant still goes to owner if valid; no grant to others that cycle.
REQ-028 On forced release (MAX_LOCK) ptr SHALL advance past owner so another valid requester wins next.
REQ-029 Back-to-back grants every cycle SHALL be supported; throughput 1 read/cycle.
REQ-030 grant_cnt SHALL increment on each accepted request and wrap from 16'hFFFF to 0.
REQ-031 fixed_prio change SHALL take effect in same cycle and SHALL NOT break an active lock.

Reset
REQ-032 On rst: state=ARB, ptr=0, lock_cnt=0, lock_owner=0, rsp_valid=0, grant_cnt=0.
REQ-033 During rst cycle req_ready=0 and rom_ce=0; reset mid-operation SHALL drop any in-flight response (no rsp_valid in cycle after rst).

Structure
REQ-034 Package rom_arb_pkg SHALL hold state enum (ARB, LOCKED), default parameter constants and grant_cnt width.
REQ-035 Sub-module rr_pick SHALL compute one-hot winner from request vector, start pointer and fixed_prio flag (purely combinational).
REQ-036 ROM itself SHALL be external; shares clk and rst.

Verification
REQ-037 All 4 valid continuously, round-robin, no lock, after reset -> grants 0,1,2,3,0,...; rsp_valid one-hot follows one cycle later.
REQ-038 Requester 2 alone, addr=12'h400 -> rom_addr=12'h400, rom_ce=1; next cycle rsp_valid=4'b0100, rsp_data=ROM[0x400].
REQ-039 Requester 1 lock=1 valid, others valid -> 16 consecutive grants to 1, then grant to 2; grant_cnt=17 after 17 grants.
REQ-040 fixed_prio=1, req_valid=4'b1010 -> requester 1 wins each cycle; requester 3 starves.
REQ-041 rst asserted in cycle after grant to 0 -> rsp_valid stays 0, grant_cnt=0, ptr=0.
REQ-042 grant_cnt preloaded via 65535 grants -> next grant wraps to 0.
